// File: rtl/apu_sample_capture.sv
// rtl/apu_sample_capture.sv - box-filter decimator for N audio channels feeding a FWFT frame FIFO
module apu_sample_capture #(
  parameter int CHANNELS   = 2,
  parameter int SAMPLE_W   = 16,
  parameter int DECIM_LOG2 = 7,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [CHANNELS*SAMPLE_W-1:0]   sample_i,
  output logic                           frame_valid,
  input  logic                           frame_ready,
  output logic [CHANNELS*SAMPLE_W-1:0]   frame_data,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_count,
  output logic                           overflow,
  input  logic                           clear_ovf
);

  localparam int ACC_W   = SAMPLE_W + DECIM_LOG2;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int FRAME_W = CHANNELS * SAMPLE_W;
  localparam logic [DECIM_LOG2-1:0] PHASE_LAST = '1;
  localparam logic [PTR_W:0]        DEPTH_CNT  = FIFO_DEPTH[PTR_W:0];

  logic [DECIM_LOG2-1:0] phase_q, phase_d;
  logic [ACC_W-1:0]      acc_q [CHANNELS];
  logic [ACC_W-1:0]      acc_d [CHANNELS];
  logic [ACC_W-1:0]      sum_w [CHANNELS];
  logic [FRAME_W-1:0]    frame_word;
  logic                  terminal;

  logic [FRAME_W-1:0]    mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]        count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  pop, push_ok, full;

  always_comb begin
    terminal   = enable && (phase_q == PHASE_LAST);
    phase_d    = enable ? phase_q + 1'b1 : '0;
    frame_word = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      sum_w[c] = acc_q[c] + {{DECIM_LOG2{sample_i[c*SAMPLE_W+SAMPLE_W-1]}},
                             sample_i[c*SAMPLE_W +: SAMPLE_W]};
      // Top SAMPLE_W bits of the sum are exactly (sum >>> DECIM_LOG2) truncated.
      frame_word[c*SAMPLE_W +: SAMPLE_W] = sum_w[c][DECIM_LOG2 +: SAMPLE_W];
      acc_d[c] = (!enable || terminal) ? '0 : sum_w[c];
    end
  end

  assign full    = (count_q == DEPTH_CNT);
  assign pop     = (count_q != '0) && frame_ready;
  assign push_ok = terminal && (!full || pop);

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    overflow_d = overflow_q;
    if (terminal && !push_ok) overflow_d = 1'b1;
    else if (clear_ovf)       overflow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) acc_q[c] <= '0;
    end else begin
      phase_q    <= phase_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      for (int c = 0; c < CHANNELS; c++) acc_q[c] <= acc_d[c];
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= frame_word;
  end

  assign frame_valid = (count_q != '0);
  assign frame_data  = frame_valid ? mem_q[rd_ptr_q] : '0;
  assign fifo_count  = count_q;
  assign overflow    = overflow_q;

endmodule
